// File: rtl/control_decode_pipe.sv
// control_decode_pipe: registered RV32I control decoder with a valid/ready ID/EX register,
// load-use bubble insertion and MUL/DIV occupancy stall. Define RV32M_EN to decode RV32M.
module control_decode_pipe #(
  parameter int BITS       = 32,
  parameter int MULDIV_LAT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_alu_ctrl,
  output logic        out_branch,
  output logic        out_mem_read,
  output logic        out_mem_to_reg,
  output logic        out_mem_write,
  output logic        out_alu_src,
  output logic        out_reg_write,
  output logic [4:0]  out_rd,
  output logic [4:0]  out_rs1,
  output logic [4:0]  out_rs2,
  output logic        out_illegal,
  output logic        muldiv_busy
);
  // state    | meaning
  // RUN      | issuing normally
  // BUBBLE   | load-use hazard cycle: input stalled, pending load dropped at the edge
  // MD_WAIT  | M-extension op occupying EX; counter holds the remaining cycles

  localparam logic [1:0] ST_RUN = 2'd0, ST_BUBBLE = 2'd1, ST_MD_WAIT = 2'd2;

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LOAD = 7'b0000011,
                         OP_STORE = 7'b0100011, OP_BRANCH = 7'b1100011, OP_AUIPC = 7'b0010111,
                         OP_JAL = 7'b1101111, OP_JALR = 7'b1100111;

  localparam logic [4:0] ALU_NOP = 5'd0, ALU_ADD = 5'd1, ALU_SUB = 5'd2, ALU_SLL = 5'd3,
                         ALU_SLT = 5'd4, ALU_SLTU = 5'd5, ALU_XOR = 5'd6, ALU_SRL = 5'd7,
                         ALU_SRA = 5'd8, ALU_OR = 5'd9, ALU_AND = 5'd10, ALU_BEQ = 5'd11,
                         ALU_BNE = 5'd12, ALU_BLT = 5'd13, ALU_BGE = 5'd14, ALU_BLTU = 5'd15,
                         ALU_BGEU = 5'd16, ALU_AUIPC = 5'd17, ALU_JAL = 5'd18, ALU_JALR = 5'd19;
`ifdef RV32M_EN
  localparam logic [4:0] ALU_MUL = 5'd20, ALU_REMU = 5'd27;
`endif

  localparam int CW = (MULDIV_LAT > 1) ? $clog2(MULDIV_LAT) : 1;
  // Datapath width has no bearing on control decode.
  localparam int bits_unused = BITS;

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [4:0] rd, rs1, rs2;
  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  logic [4:0] dec_alu;
  logic dec_branch, dec_mem_read, dec_mem_write, dec_alu_src, dec_reg_write, dec_illegal;
  logic use_rs1, use_rs2;

  always_comb begin
    dec_alu = ALU_NOP;
    dec_branch = 1'b0;
    dec_mem_read = 1'b0;
    dec_mem_write = 1'b0;
    dec_alu_src = 1'b0;
    dec_reg_write = 1'b0;
    dec_illegal = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (opcode)
      OP_R: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        dec_reg_write = 1'b1;
        case (funct7)
          7'b0000000:
            case (funct3)
              3'b000:  dec_alu = ALU_ADD;
              3'b001:  dec_alu = ALU_SLL;
              3'b010:  dec_alu = ALU_SLT;
              3'b011:  dec_alu = ALU_SLTU;
              3'b100:  dec_alu = ALU_XOR;
              3'b101:  dec_alu = ALU_SRL;
              3'b110:  dec_alu = ALU_OR;
              default: dec_alu = ALU_AND;
            endcase
          7'b0100000:
            case (funct3)
              3'b000:  dec_alu = ALU_SUB;
              3'b101:  dec_alu = ALU_SRA;
              default: dec_illegal = 1'b1;
            endcase
`ifdef RV32M_EN
          7'b0000001: dec_alu = ALU_MUL + {2'b00, funct3};
`endif
          default: dec_illegal = 1'b1;
        endcase
      end
      OP_I: begin
        use_rs1 = 1'b1;
        dec_alu_src = 1'b1;
        dec_reg_write = 1'b1;
        case (funct3)
          3'b000:  dec_alu = ALU_ADD;
          3'b001:  if (funct7 == 7'b0000000) dec_alu = ALU_SLL; else dec_illegal = 1'b1;
          3'b010:  dec_alu = ALU_SLT;
          3'b011:  dec_alu = ALU_SLTU;
          3'b100:  dec_alu = ALU_XOR;
          3'b101:
            if (funct7 == 7'b0000000) dec_alu = ALU_SRL;
            else if (funct7 == 7'b0100000) dec_alu = ALU_SRA;
            else dec_illegal = 1'b1;
          3'b110:  dec_alu = ALU_OR;
          default: dec_alu = ALU_AND;
        endcase
      end
      OP_LOAD: begin
        use_rs1 = 1'b1;
        dec_alu = ALU_ADD;
        dec_alu_src = 1'b1;
        dec_mem_read = 1'b1;
        dec_reg_write = 1'b1;
        dec_illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      OP_STORE: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        dec_alu = ALU_ADD;
        dec_alu_src = 1'b1;
        dec_mem_write = 1'b1;
        dec_illegal = funct3[2] || (funct3 == 3'b011);
      end
      OP_BRANCH: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        dec_branch = 1'b1;
        case (funct3)
          3'b000:  dec_alu = ALU_BEQ;
          3'b001:  dec_alu = ALU_BNE;
          3'b100:  dec_alu = ALU_BLT;
          3'b101:  dec_alu = ALU_BGE;
          3'b110:  dec_alu = ALU_BLTU;
          3'b111:  dec_alu = ALU_BGEU;
          default: dec_illegal = 1'b1;
        endcase
      end
      OP_AUIPC: begin
        dec_alu = ALU_AUIPC;
        dec_alu_src = 1'b1;
        dec_reg_write = 1'b1;
      end
      OP_JAL: begin
        dec_alu = ALU_JAL;
        dec_alu_src = 1'b1;
        dec_branch = 1'b1;
        dec_reg_write = 1'b1;
      end
      OP_JALR: begin
        use_rs1 = 1'b1;
        dec_alu = ALU_JALR;
        dec_alu_src = 1'b1;
        dec_branch = 1'b1;
        dec_reg_write = 1'b1;
        dec_illegal = (funct3 != 3'b000);
      end
      default: dec_illegal = 1'b1;
    endcase
    // Illegal instructions still flow downstream, but inert.
    if (dec_illegal) begin
      dec_alu = ALU_NOP;
      dec_branch = 1'b0;
      dec_mem_read = 1'b0;
      dec_mem_write = 1'b0;
      dec_alu_src = 1'b0;
      dec_reg_write = 1'b0;
    end
    if (rd == 5'd0) dec_reg_write = 1'b0;
  end

  logic [1:0] state_q, state_d, state;
  logic [CW-1:0] cnt_q, cnt_d;
  logic load_pend_q, load_pend_d;
  logic [4:0] load_rd_q, load_rd_d;
  logic valid_q, branch_q, mem_read_q, mem_write_q, alu_src_q, reg_write_q, illegal_q;
  logic [4:0] alu_q, rd_q, rs1_q, rs2_q;
  logic hazard, accept, take, md_start;

  assign hazard = load_pend_q && in_valid &&
                  ((use_rs1 && (rs1 == load_rd_q)) || (use_rs2 && (rs2 == load_rd_q)));
  // The bubble is the hazard cycle itself, so it never outlives a single cycle.
  assign state    = ((state_q == ST_RUN) && hazard) ? ST_BUBBLE : state_q;
  assign in_ready = (state == ST_RUN) && !flush && (!valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign take     = valid_q && out_ready;

`ifdef RV32M_EN
  assign md_start    = take && (alu_q >= ALU_MUL) && (alu_q <= ALU_REMU) && (MULDIV_LAT > 1);
  assign muldiv_busy = (state_q == ST_MD_WAIT);
`else
  assign md_start    = 1'b0;
  assign muldiv_busy = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    load_pend_d = load_pend_q;
    load_rd_d = load_rd_q;
    if (flush) begin
      state_d = ST_RUN;
      cnt_d = '0;
      load_pend_d = 1'b0;
    end else begin
      case (state)
        ST_MD_WAIT:
          if (cnt_q == CW'(1)) begin
            state_d = ST_RUN;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        ST_BUBBLE: begin
          state_d = ST_RUN;
          load_pend_d = 1'b0;
        end
        default:
          if (md_start) begin
            state_d = ST_MD_WAIT;
            cnt_d = CW'(MULDIV_LAT - 1);
          end
      endcase
      if (accept) begin
        load_pend_d = dec_mem_read && (rd != 5'd0);
        load_rd_d = rd;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q <= '0;
      load_pend_q <= 1'b0;
      load_rd_q <= 5'd0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      load_pend_q <= load_pend_d;
      load_rd_q <= load_rd_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      alu_q <= ALU_NOP;
      branch_q <= 1'b0;
      mem_read_q <= 1'b0;
      mem_write_q <= 1'b0;
      alu_src_q <= 1'b0;
      reg_write_q <= 1'b0;
      illegal_q <= 1'b0;
      rd_q <= 5'd0;
      rs1_q <= 5'd0;
      rs2_q <= 5'd0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q <= 1'b1;
      alu_q <= dec_alu;
      branch_q <= dec_branch;
      mem_read_q <= dec_mem_read;
      mem_write_q <= dec_mem_write;
      alu_src_q <= dec_alu_src;
      reg_write_q <= dec_reg_write;
      illegal_q <= dec_illegal;
      rd_q <= rd;
      rs1_q <= rs1;
      rs2_q <= rs2;
    end else if (take) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid      = valid_q;
  assign out_alu_ctrl   = alu_q;
  assign out_branch     = branch_q;
  assign out_mem_read   = mem_read_q;
  assign out_mem_to_reg = mem_read_q;
  assign out_mem_write  = mem_write_q;
  assign out_alu_src    = alu_src_q;
  assign out_reg_write  = reg_write_q;
  assign out_illegal    = illegal_q;
  assign out_rd         = rd_q;
  assign out_rs1        = rs1_q;
  assign out_rs2        = rs2_q;
endmodule

// File: tb/tb_control_decode_pipe.sv
// Randomized bench for control_decode_pipe against a transaction-level reference model.
module tb_control_decode_pipe;
  localparam int LAT = 4;
`ifdef RV32M_EN
  localparam bit M_ON = 1'b1;
`else
  localparam bit M_ON = 1'b0;
`endif

  localparam logic [4:0] A_NOP = 0, A_ADD = 1, A_SUB = 2, A_SLL = 3, A_SLT = 4, A_SLTU = 5,
                         A_XOR = 6, A_SRL = 7, A_SRA = 8, A_OR = 9, A_AND = 10, A_BEQ = 11,
                         A_BNE = 12, A_BLT = 13, A_BGE = 14, A_BLTU = 15, A_BGEU = 16,
                         A_AUIPC = 17, A_JAL = 18, A_JALR = 19, A_MUL = 20, A_REMU = 27;

  localparam logic [31:0] I_ADD3 = 32'h002081B3, I_LW5 = 32'h0000A283, I_ADD6 = 32'h00228333,
                          I_MUL7 = 32'h022083B3, I_SUB = 32'h40208233, I_NOP0 = 32'h00000013;

  typedef struct packed {
    logic [4:0] alu;
    logic br, mr, mtr, mw, as, rw, ill;
  } ctl_t;

  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [31:0] instr = '0;
  logic in_ready, out_valid, out_branch, out_mem_read, out_mem_to_reg, out_mem_write;
  logic out_alu_src, out_reg_write, out_illegal, muldiv_busy;
  logic [4:0] out_alu_ctrl, out_rd, out_rs1, out_rs2;

  always #5 clk = ~clk;

  control_decode_pipe #(.BITS(32), .MULDIV_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_alu_ctrl(out_alu_ctrl),
    .out_branch(out_branch), .out_mem_read(out_mem_read), .out_mem_to_reg(out_mem_to_reg),
    .out_mem_write(out_mem_write), .out_alu_src(out_alu_src), .out_reg_write(out_reg_write),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_illegal(out_illegal),
    .muldiv_busy(muldiv_busy));

  int n_chk = 0, n_err = 0, busy_seen = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  logic [4:0] arith_tab [0:7] = '{A_ADD, A_SLL, A_SLT, A_SLTU, A_XOR, A_SRL, A_OR, A_AND};
  logic [4:0] br_tab    [0:7] = '{A_BEQ, A_BNE, A_NOP, A_NOP, A_BLT, A_BGE, A_BLTU, A_BGEU};

  function automatic ctl_t ref_decode(input logic [31:0] ins);
    ctl_t c;
    logic ok;
    logic [6:0] op, f7;
    logic [2:0] f3;
    op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    c = '0;
    ok = 1'b1;
    case (op)
      7'h33: begin
        c.rw = 1;
        if (f7 == 7'h00) c.alu = arith_tab[f3];
        else if (f7 == 7'h20 && f3 == 3'd0) c.alu = A_SUB;
        else if (f7 == 7'h20 && f3 == 3'd5) c.alu = A_SRA;
        else if (f7 == 7'h01 && M_ON) c.alu = A_MUL + 5'(f3);
        else ok = 0;
      end
      7'h13: begin
        c.rw = 1; c.as = 1;
        if (f3 == 3'd1) begin c.alu = A_SLL; ok = (f7 == 7'h00); end
        else if (f3 == 3'd5) begin
          if (f7 == 7'h00) c.alu = A_SRL;
          else if (f7 == 7'h20) c.alu = A_SRA;
          else ok = 0;
        end else c.alu = arith_tab[f3];
      end
      7'h03: begin
        c.alu = A_ADD; c.mr = 1; c.mtr = 1; c.rw = 1; c.as = 1;
        ok = (f3 == 0) || (f3 == 1) || (f3 == 2) || (f3 == 4) || (f3 == 5);
      end
      7'h23: begin c.alu = A_ADD; c.mw = 1; c.as = 1; ok = (f3 <= 3'd2); end
      7'h63: begin c.br = 1; c.alu = br_tab[f3]; ok = (f3 != 3'd2) && (f3 != 3'd3); end
      7'h17: begin c.alu = A_AUIPC; c.as = 1; c.rw = 1; end
      7'h6F: begin c.alu = A_JAL; c.as = 1; c.br = 1; c.rw = 1; end
      7'h67: begin c.alu = A_JALR; c.as = 1; c.br = 1; c.rw = 1; ok = (f3 == 3'd0); end
      default: ok = 0;
    endcase
    if (!ok) begin c = '0; c.ill = 1; end
    if (ins[11:7] == 5'd0) c.rw = 0;
    return c;
  endfunction

  function automatic logic reads_reg(input logic [31:0] ins, input logic [4:0] r);
    logic [6:0] op;
    logic r1, r2;
    op = ins[6:0];
    r1 = (op == 7'h33) || (op == 7'h13) || (op == 7'h03) || (op == 7'h23) ||
         (op == 7'h63) || (op == 7'h67);
    r2 = (op == 7'h33) || (op == 7'h23) || (op == 7'h63);
    return (r1 && ins[19:15] == r) || (r2 && ins[24:20] == r);
  endfunction

  // Reference model: the ID/EX slot, the pending load and remaining MUL/DIV cycles.
  logic m_ov = 0, m_lp = 0;
  logic [4:0] m_lrd = 0, m_rd = 0, m_rs1 = 0, m_rs2 = 0;
  ctl_t m_ctl = '0;
  int m_busy_left = 0;

  task automatic model_reset();
    m_ov = 0; m_lp = 0; m_lrd = 0; m_rd = 0; m_rs1 = 0; m_rs2 = 0; m_ctl = '0; m_busy_left = 0;
  endtask

  // Called at posedge+1; returns at the following posedge+1.
  task automatic cycle(input logic iv, input logic [31:0] ins, input logic ordy, input logic fl);
    logic hz, busy, rdy, acc, take;
    in_valid = iv; instr = ins; out_ready = ordy; flush = fl;
    #4;
    busy = (m_busy_left > 0);
    hz = m_lp && iv && reads_reg(ins, m_lrd);
    rdy = !busy && !hz && !fl && (!m_ov || ordy);
    check("in_ready", in_ready, rdy);
    check("muldiv_busy", muldiv_busy, busy);
    if (muldiv_busy) busy_seen++;
    acc = iv && rdy;
    take = m_ov && ordy;
    if (fl) begin
      m_ov = 0; m_lp = 0; m_busy_left = 0;
    end else begin
      if (busy) m_busy_left--;
      else if (take && m_ctl.alu >= A_MUL && m_ctl.alu <= A_REMU && LAT > 1)
        m_busy_left = LAT - 1;
      if (acc) begin
        m_ctl = ref_decode(ins);
        m_lp = m_ctl.mr && (ins[11:7] != 0);
        m_lrd = ins[11:7];
        m_rd = ins[11:7]; m_rs1 = ins[19:15]; m_rs2 = ins[24:20];
        m_ov = 1;
      end else begin
        if (hz && !busy) m_lp = 0;
        if (take) m_ov = 0;
      end
    end
    @(posedge clk); #1;
    check("out_valid", out_valid, m_ov);
    check("bundle", {out_alu_ctrl, out_branch, out_mem_read, out_mem_to_reg, out_mem_write,
                     out_alu_src, out_reg_write, out_illegal, out_rd, out_rs1, out_rs2},
                    {m_ctl, m_rd, m_rs1, m_rs2});
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [0:9];
    logic [6:0] f7;
    ops = '{7'h33, 7'h33, 7'h13, 7'h03, 7'h03, 7'h23, 7'h63, 7'h17, 7'h6F, 7'h67};
    case ($urandom_range(0, 3))
      0: f7 = 7'h00;
      1: f7 = 7'h20;
      2: f7 = 7'h01;
      default: f7 = 7'($urandom);
    endcase
    if ($urandom_range(0, 9) == 0) return $urandom;
    return {f7, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 3'($urandom),
            5'($urandom_range(0, 7)), ops[$urandom_range(0, 9)]};
  endfunction

  initial begin
    @(posedge clk); #1;
    check("rst_valid", out_valid, 0);
    check("rst_bundle", {out_alu_ctrl, out_branch, out_mem_read, out_mem_to_reg, out_mem_write,
                         out_alu_src, out_reg_write, out_illegal, out_rd, out_rs1, out_rs2}, 0);
    check("rst_busy", muldiv_busy, 0);
    @(posedge clk); #1;
    rst = 0;

    cycle(1, I_ADD3, 1, 0);
    check("add_alu", out_alu_ctrl, A_ADD);
    check("add_rw", out_reg_write, 1);
    check("add_src", out_alu_src, 0);
    check("add_rd", out_rd, 3);

    cycle(1, I_LW5, 1, 0);
    cycle(1, I_ADD6, 1, 0);
    check("lu_drain", out_valid, 0);
    cycle(1, I_ADD6, 1, 0);
    check("lu_issue_rd", out_rd, 6);

    busy_seen = 0;
    cycle(1, I_MUL7, 1, 0);
    check("mul_illegal", out_illegal, M_ON ? 0 : 1);
    check("mul_alu", out_alu_ctrl, M_ON ? A_MUL : A_NOP);
    cycle(0, 0, 1, 0);
    for (int i = 0; i < 4; i++) cycle(1, I_ADD3, 1, 0);
    check("md_cycles", busy_seen, M_ON ? LAT - 1 : 0);

    for (int i = 0; i < 5; i++) cycle(1, I_SUB, 0, 0);
    for (int i = 0; i < 4; i++) cycle(1, (i % 2) ? I_SUB : I_ADD6, 1, 0);

    cycle(1, I_MUL7, 1, 0);
    cycle(1, I_LW5, 1, 0);
    cycle(1, I_ADD6, 1, 1);
    check("flush_valid", out_valid, 0);
    check("flush_busy", muldiv_busy, 0);
    cycle(1, I_NOP0, 1, 0);
    check("x0_rw", out_reg_write, 0);

    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 9) < 7,
            $urandom_range(0, 24) == 0);

    cycle(1, I_MUL7, 1, 0);
    cycle(1, I_LW5, 1, 0);
    #2 rst = 1;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_busy", muldiv_busy, 0);
    check("arst_alu", out_alu_ctrl, A_NOP);
    model_reset();
    @(posedge clk); #1;
    rst = 0;
    for (int i = 0; i < 200; i++)
      cycle($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 9) < 7, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/control_decode_pipe.md
Name: control_decode_pipe

Overview:
Registered, flow-controlled successor to the combinational RV32IM control decoder. It decodes a full 32-bit instruction into the ALU-control and datapath-control bundle and holds the result in an ID/EX output register with a valid/ready handshake. It also inserts load-use bubbles and holds issue while a multi-cycle MUL/DIV operation occupies EX. It sits between instruction fetch and the EX stage.

Parameters:
BITS, 32, datapath width; instruction width fixed at 32.
MULDIV_LAT, 4, EX occupancy in cycles of an M-extension op; legal range is 1 or more.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  reset; asynchronous and active-high.
in_valid  input  1  instruction present.
in_ready  output  1  instruction accepted this cycle when in_valid is also high.
instr  input  32  instruction word.
flush  input  1  synchronous pipeline flush.
out_valid  output  1  decoded bundle valid.
out_ready  input  1  EX accepts the bundle.
out_alu_ctrl  output  5  `ALUCTRL_* code from alu_control_def.v.
out_branch, out_mem_read, out_mem_to_reg, out_mem_write, out_alu_src, out_reg_write  output  1 each  datapath controls.
out_rd, out_rs1, out_rs2  output  5 each  register indices.
out_illegal  output  1  unsupported opcode, funct7 or funct3.
muldiv_busy  output  1  MUL/DIV occupying EX.

Behaviour:
- Reset values: out_valid=0, out_alu_ctrl=`ALUCTRL_NOP, all 1-bit controls 0, indices 0, out_illegal=0, muldiv_busy=0. Internally: state=RUN, counter=0, load_pend=0.
- Latency: one cycle. A bundle accepted at edge N is visible after edge N.
- Output register is loaded when in_valid && in_ready. It is cleared (out_valid=0) when out_valid && out_ready && !(in_valid && in_ready).
- in_ready = (state==RUN) && !hazard && !flush && (!out_valid || out_ready).
- Decode table:
  - R (0110011) and I-calc (0010011): same funct3/funct7 mapping as the existing control unit.
  - Load (0000011) and store (0100011): ADD.
  - Branch (1100011): BEQ, BNE, BLT, BGE, BLTU, BGEU by funct3.
  - AUIPC, JAL, JALR: their own codes.
- Control signals:
  - ALUSrc=1 for I-calc, Load, S, AUIPC, JAL, JALR.
  - Branch=1 for SB, JAL, JALR.
  - MemRead=MemtoReg=1 for Load only.
  - MemWrite=1 for S only.
  - RegWrite=1 for R, I-calc, Load, AUIPC, JAL, JALR; forced to 0 when rd==0.
- Illegal instruction: out_illegal=1, ALUCtrl NOP, all write/mem/branch controls 0. It is still issued downstream.
- Register use: rs1 is used by all except JAL and AUIPC. rs2 is used by R, S, SB.
- Load-use hazard: on issue of a Load with rd!=0, set load_pend=1 and latch its rd. hazard = load_pend && in_valid && a used rs equals the latched rd.
  - On a hazard, state=BUBBLE for exactly one cycle with in_ready=0.
  - The register drains to out_valid=0 once the load is taken, then the state returns to RUN.
  - load_pend clears on the first issue after the load, or when the bubble completes.
- MUL/DIV occupancy: when a bundle with ALUCtrl in MUL..REMU is taken downstream and MULDIV_LAT>1:
  - state goes to MD_WAIT and the counter is loaded with MULDIV_LAT-1.
  - In MD_WAIT: muldiv_busy=1, in_ready=0, and the counter decrements each cycle.
  - At counter==1 the block returns to RUN with muldiv_busy=0 on the next cycle.
  - MULDIV_LAT=1 never enters MD_WAIT.
- Flush has priority over every other event. On the next edge: out_valid=0, load_pend=0, counter=0, state=RUN. An input presented in the flush cycle is not accepted.
- Simultaneous out-take and new accept: the register is reloaded and out_valid stays 1, giving back-to-back throughput of one per cycle.
- Reset asserted mid-operation returns all state to reset values immediately; it is asynchronous.

Optional Feature:
RV32M_EN.
- Defined: funct7=0000001 on R-type decodes MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU, and MD_WAIT tracking is active.
- Undefined: those encodings decode as illegal (out_illegal=1, ALUCtrl NOP), MD_WAIT is unreachable, and muldiv_busy is tied to 0.

Test Plan:
- Reset released, then add x3,x1,x2 (0x002081B3) with out_ready=1 -> after one edge: out_valid=1, ALUCTRL_ADD, reg_write=1, alu_src=0, rd=3.
- lw x5,0(x1) followed by add x6,x5,x2 -> one bubble cycle with in_ready=0; the add issues two cycles after the lw.
- mul x7,x1,x2 with MULDIV_LAT=4 and RV32M_EN defined -> muldiv_busy=1 and in_ready=0 for 3 cycles after take, then accept resumes.
- Same mul with RV32M_EN undefined -> out_illegal=1, ALUCTRL_NOP, reg_write=0, no stall.
- out_ready=0 for 5 cycles with in_valid=1 -> bundle held stable, in_ready=0; out_ready=1 -> back-to-back issue at one per cycle.
- flush asserted during MD_WAIT with a pending load -> next cycle: out_valid=0, muldiv_busy=0, in_ready=1; addi x0,x0,0 yields reg_write=0.
